// File: rtl/geodash_pkg.sv
// Shared types and screen geometry for the Geometry Dash display pipeline.
package geodash_pkg;

  typedef enum logic [1:0] {IDLE, RUN, CRASH} sched_state_t;

  localparam logic [10:0] SCREEN_W  = 11'd640;
  localparam logic [10:0] FLOOR_ROW = 11'd437;
  localparam logic [10:0] CEIL_ROW  = 11'd42;

  // Spawn just past the right edge; park far outside any DrawX.
  localparam logic [10:0] DEF_SPAWN_X  = SCREEN_W + 11'd20;
  localparam logic [10:0] DEF_PARK_X   = 11'd1500;
  localparam logic [10:0] DEF_FLOOR_TY = FLOOR_ROW - 11'd9;
  localparam logic [10:0] DEF_CEIL_TY  = CEIL_ROW + 11'd5;

  // 16-bit Fibonacci LFSR, taps 16/14/13/11, shifting left.
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

endpackage

// File: rtl/obstacle_lane.sv
// One obstacle lane: gap countdown, spawn at the right edge, scroll left, retire off the left edge.
module obstacle_lane
  import geodash_pkg::*;
#(
  parameter logic [6:0]  GAP_INIT = 7'd24,
  parameter logic [6:0]  MIN_GAP  = 7'd24,
  parameter logic [10:0] SPAWN_X  = DEF_SPAWN_X,
  parameter logic [10:0] PARK_X   = DEF_PARK_X
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        tick,
  input  logic [3:0]  speed,
  input  logic [5:0]  gap_seed,
  input  logic        flip_seed,
  input  logic        enable,
  input  logic        clear,
  output logic [10:0] X,
  output logic        flip,
  output logic        retire
);

  logic        r_active, w_active_next;
  logic [10:0] r_x, w_x_next;
  logic [6:0]  r_gap, w_gap_next;
  logic        r_flip, w_flip_next;
  logic        w_step;
  logic        w_retire;

  assign w_step   = tick & enable & ~clear;
  // Retire before subtracting so X never wraps below zero.
  assign w_retire = w_step & r_active & (r_x <= {7'd0, speed});

  always_comb begin
    w_active_next = r_active;
    w_x_next      = r_x;
    w_gap_next    = r_gap;
    w_flip_next   = r_flip;
    if (clear) begin
      w_active_next = 1'b0;
      w_x_next      = PARK_X;
      w_gap_next    = GAP_INIT;
      w_flip_next   = 1'b0;
    end else if (w_step) begin
      if (r_active) begin
        if (w_retire) begin
          w_active_next = 1'b0;
          w_x_next      = PARK_X;
          w_flip_next   = 1'b0;
          w_gap_next    = MIN_GAP + {1'b0, gap_seed};
        end else begin
          w_x_next = r_x - {7'd0, speed};
        end
      end else if (r_gap <= 7'd1) begin
        // Spawn on the tick that exhausts the gap: a gap of N spawns on the Nth tick.
        w_active_next = 1'b1;
        w_x_next      = SPAWN_X;
        w_flip_next   = flip_seed;
      end else begin
        w_gap_next = r_gap - 7'd1;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      r_active <= 1'b0;
      r_x      <= PARK_X;
      r_gap    <= GAP_INIT;
      r_flip   <= 1'b0;
    end else begin
      r_active <= w_active_next;
      r_x      <= w_x_next;
      r_gap    <= w_gap_next;
      r_flip   <= w_flip_next;
    end
  end

  assign X      = r_x;
  assign flip   = r_flip;
  assign retire = w_retire;

endmodule

// File: rtl/obstacle_scheduler.sv
// Frame-rate obstacle controller: spawns, scrolls and retires a spike and a column lane.
// Define OBSTACLE_SPEEDUP_EN to raise scroll speed with score.
module obstacle_scheduler
  import geodash_pkg::*;
#(
  parameter logic [10:0] SPAWN_X    = DEF_SPAWN_X,
  parameter logic [10:0] PARK_X     = DEF_PARK_X,
  parameter logic [10:0] FLOOR_TY   = DEF_FLOOR_TY,
  parameter logic [10:0] CEIL_TY    = DEF_CEIL_TY,
  parameter logic [3:0]  BASE_SPEED = 4'd4,
  parameter logic [6:0]  MIN_GAP    = 7'd24,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        frame_clk,
  input  logic        run,
  input  logic        will_collide,
  output logic [10:0] Triangle_X,
  output logic [10:0] Triangle_Y,
  output logic        is_flipped,
  output logic [10:0] Column_X,
  output logic        is_column_flipped,
  output logic        crashed,
  output logic [7:0]  score
);

  sched_state_t r_state, w_state_next;
  logic         r_frame_clk_q;
  logic [15:0]  r_lfsr;
  logic [7:0]   r_score, w_score_next;
  logic         w_frame_tick;
  logic         w_lane_en;
  logic         w_lane_step;
  logic         w_clear;
  logic [3:0]   w_speed;
  logic         w_retire_spike, w_retire_column;
  logic [8:0]   w_score_sum;

  assign w_frame_tick = frame_clk & ~r_frame_clk_q;
  // Collision and run=0 both block the lane update in the same cycle.
  assign w_lane_en    = (r_state == RUN) & run & ~will_collide;
  assign w_lane_step  = w_frame_tick & w_lane_en;
  assign w_clear      = (r_state == IDLE);

`ifdef OBSTACLE_SPEEDUP_EN
  assign w_speed = BASE_SPEED + {1'b0, r_score[7:5]};
`else
  assign w_speed = BASE_SPEED;
`endif

  obstacle_lane #(
    .GAP_INIT (MIN_GAP),
    .MIN_GAP  (MIN_GAP),
    .SPAWN_X  (SPAWN_X),
    .PARK_X   (PARK_X)
  ) u_spike (
    .Clk       (Clk),
    .Reset     (Reset),
    .tick      (w_frame_tick),
    .speed     (w_speed),
    .gap_seed  (r_lfsr[5:0]),
    .flip_seed (r_lfsr[6]),
    .enable    (w_lane_en),
    .clear     (w_clear),
    .X         (Triangle_X),
    .flip      (is_flipped),
    .retire    (w_retire_spike)
  );

  obstacle_lane #(
    .GAP_INIT (MIN_GAP + 7'd12),
    .MIN_GAP  (MIN_GAP),
    .SPAWN_X  (SPAWN_X),
    .PARK_X   (PARK_X)
  ) u_column (
    .Clk       (Clk),
    .Reset     (Reset),
    .tick      (w_frame_tick),
    .speed     (w_speed),
    .gap_seed  (r_lfsr[13:8]),
    .flip_seed (r_lfsr[7]),
    .enable    (w_lane_en),
    .clear     (w_clear),
    .X         (Column_X),
    .flip      (is_column_flipped),
    .retire    (w_retire_column)
  );

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE:    if (run) w_state_next = RUN;
      RUN: begin
        if (!run)              w_state_next = IDLE;
        else if (will_collide) w_state_next = CRASH;
      end
      CRASH:   if (!run) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  assign w_score_sum = {1'b0, r_score} + {8'd0, w_retire_spike} + {8'd0, w_retire_column};

  always_comb begin
    w_score_next = r_score;
    if ((r_state == IDLE) && run) begin
      w_score_next = 8'd0;
    end else if (w_lane_step) begin
      w_score_next = w_score_sum[8] ? 8'hFF : w_score_sum[7:0];
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      r_state       <= IDLE;
      r_frame_clk_q <= 1'b0;
      r_lfsr        <= LFSR_SEED;
      r_score       <= 8'd0;
    end else begin
      r_state       <= w_state_next;
      r_frame_clk_q <= frame_clk;
      r_score       <= w_score_next;
      if (w_lane_step) r_lfsr <= lfsr_next(r_lfsr);
    end
  end

  assign Triangle_Y = is_flipped ? CEIL_TY : FLOOR_TY;
  assign crashed    = (r_state == CRASH);
  assign score      = r_score;

endmodule
